// File: rtl/psum_tagger.sv
// psum_tagger
//
// Collects one partial sum per round from each of PE1..PE3 and, once warmed
// up, one membrane-potential value from memory. Each value is tagged with
// its 2-bit source index and serialized onto a single output channel held
// in a one-entry output register. During the first FT rounds the memory
// source is not required, so it is never granted.
//
// Handshake: every channel uses strict valid/ready. A transfer happens on
// a rising edge where valid & ready are both high. Ready may depend
// combinationally on valid. A producer must not wait for ready before
// raising valid.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high; dominates all other inputs
//   in_valid   per-source valid; bit0=mem, bit1=PE1, bit2=PE2, bit3=PE3
//   in_data    per-source value; slice s = in_data[s*WIDTH +: WIDTH]
//   in_ready   per-source accept; one-hot at the granted source or zero
//   out_valid  packet available in the output register
//   out_data   {tag[1:0], value[WIDTH-1:0]}; tag = source index
//   out_ready  downstream accept
//   round_cnt  completed rounds, saturating at FT
//   warm       high once round_cnt == FT (memory packet required)

module psum_tagger #(
  parameter int WIDTH = 8,
  parameter int FT    = 9,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           in_valid,
  input  logic [4*WIDTH-1:0]   in_data,
  output logic [3:0]           in_ready,
  output logic                 out_valid,
  output logic [WIDTH+1:0]     out_data,
  input  logic                 out_ready,
  output logic [CNTW-1:0]      round_cnt,
  output logic                 warm
);

  localparam logic [CNTW-1:0] FT_CNT = CNTW'(FT);

  logic [3:0]       sent;
  logic [1:0]       rr_ptr;

  logic [3:0]       required;
  logic [3:0]       eligible;
  logic             slot_free;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_idx;
  logic [3:0]       grant_oh;
  logic             accept;
  logic             round_done;
  logic [WIDTH-1:0] grant_data;

  assign warm = (round_cnt == FT_CNT);

  always_comb begin
    required    = {3'b111, warm};
    // The memory source is only eligible once warm; sent[0] never gets set
    // before that, so masking with required is enough.
    eligible    = in_valid & required & ~sent;
    slot_free   = !out_valid || out_ready;
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    scan_idx    = 2'd0;
    // First eligible source at or after rr_ptr, wrapping 3 -> 0.
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    grant_oh = 4'b0000;
    if (slot_free && grant_found && !reset) begin
      grant_oh[grant_idx] = 1'b1;
    end
    in_ready   = grant_oh;
    // grant_oh only selects a source whose valid is high.
    accept     = |grant_oh;
    round_done = accept && ((sent | grant_oh) == required);
    grant_data = in_data[grant_idx*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sent      <= 4'b0000;
      rr_ptr    <= 2'd0;
      round_cnt <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= {grant_idx, grant_data};
      if (round_done) begin
        sent   <= 4'b0000;
        rr_ptr <= 2'd0;
        if (round_cnt != FT_CNT) begin
          round_cnt <= round_cnt + 1'b1;
        end
      end else begin
        sent   <= sent | grant_oh;
        rr_ptr <= grant_idx + 2'd1;
      end
    end else if (out_ready) begin
      // Slot drained with nothing to refill it; out_data keeps its value.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_tagger.sv
// Testbench for psum_tagger: directed vector table for the listed corner
// cases, followed by a randomized run compared against a reference model.

module tb_psum_tagger;

  localparam int WIDTH = 8;
  localparam int FT    = 9;
  localparam int CNTW  = 8;

  logic                 clk;
  logic                 reset;
  logic [3:0]           in_valid;
  logic [4*WIDTH-1:0]   in_data;
  logic [3:0]           in_ready;
  logic                 out_valid;
  logic [WIDTH+1:0]     out_data;
  logic                 out_ready;
  logic [CNTW-1:0]      round_cnt;
  logic                 warm;

  int n_vec;
  int n_err;

  psum_tagger #(.WIDTH(WIDTH), .FT(FT), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .round_cnt (round_cnt),
    .warm      (warm)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector record ----------------
  typedef struct {
    logic        rst;
    logic        ordy;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [9:0]  e_od;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] pk(input logic [7:0] m, input logic [7:0] p1,
                                     input logic [7:0] p2, input logic [7:0] p3);
    return {p3, p2, p1, m};
  endfunction

  function automatic vec_t mk(input logic rst, input logic ordy, input logic [3:0] vld,
                              input logic [31:0] dat, input logic [3:0] e_rdy,
                              input logic e_ov, input logic [9:0] e_od,
                              input logic [7:0] e_cnt);
    vec_t v;
    v.rst = rst; v.ordy = ordy; v.vld = vld; v.dat = dat;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    return v;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; in_ready is checked before the
  // rising edge, registered outputs 1ns after it.
  task automatic drive(input logic rst, input logic ordy, input logic [3:0] vld,
                       input logic [31:0] dat);
    @(negedge clk);
    reset     = rst;
    out_ready = ordy;
    in_valid  = vld;
    in_data   = dat;
    #1;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    drive(v.rst, v.ordy, v.vld, v.dat);
    chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.e_ov));
    chk($sformatf("v%0d out_data", idx), 32'(out_data), 32'(v.e_od));
    chk($sformatf("v%0d round_cnt", idx), 32'(round_cnt), 32'(v.e_cnt));
    chk($sformatf("v%0d warm", idx), 32'(warm), 32'(v.e_cnt == 8'(FT)));
  endtask

  // ---------------- reference model ----------------
  // Tracks which sources have delivered this round, and counts how many
  // required sources are still outstanding to detect round completion.
  int          m_cnt;
  bit          m_done[4];
  int          m_ptr;
  bit          m_ov;
  logic [9:0]  m_od;

  task automatic model_reset();
    m_cnt = 0; m_ptr = 0; m_ov = 0; m_od = '0;
    for (int s = 0; s < 4; s++) m_done[s] = 0;
  endtask

  function automatic int model_grant(input logic rst, input logic ordy, input logic [3:0] vld);
    bit is_warm;
    is_warm = (m_cnt == FT);
    if (rst) return -1;
    if (m_ov && !ordy) return -1;
    for (int k = 0; k < 4; k++) begin
      int s;
      s = (m_ptr + k) % 4;
      if (vld[s] && !m_done[s] && (s != 0 || is_warm)) return s;
    end
    return -1;
  endfunction

  task automatic model_update(input logic rst, input logic ordy, input logic [31:0] dat,
                              input int g);
    int left;
    bit is_warm;
    if (rst) begin
      model_reset();
      return;
    end
    is_warm = (m_cnt == FT);
    if (g >= 0) begin
      m_ov = 1;
      m_od = {2'(g), dat[g*8 +: 8]};
      m_done[g] = 1;
      left = 0;
      for (int s = 0; s < 4; s++)
        if ((s != 0 || is_warm) && !m_done[s]) left++;
      if (left == 0) begin
        for (int s = 0; s < 4; s++) m_done[s] = 0;
        m_ptr = 0;
        if (m_cnt < FT) m_cnt++;
      end else begin
        m_ptr = (g + 1) % 4;
      end
    end else if (ordy) begin
      m_ov = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    in_data   = '0;

    // Warm-up round: mem offered but never granted.
    tbl.push_back(mk(1, 1, 4'b1111, pk(8'h22, 8'h05, 8'h06, 8'h07), 4'b0000, 0, 10'h000, 0));
    tbl.push_back(mk(0, 1, 4'b1111, pk(8'h22, 8'h05, 8'h06, 8'h07), 4'b0010, 1, 10'h105, 0));
    tbl.push_back(mk(0, 1, 4'b1111, pk(8'h22, 8'h05, 8'h06, 8'h07), 4'b0100, 1, 10'h206, 0));
    tbl.push_back(mk(0, 1, 4'b1111, pk(8'h22, 8'h05, 8'h06, 8'h07), 4'b1000, 1, 10'h307, 1));
    tbl.push_back(mk(0, 1, 4'b0000, pk(8'h22, 8'h05, 8'h06, 8'h07), 4'b0000, 0, 10'h307, 1));

    // Warm transition: nine PE-only rounds, then memory joins in tag order.
    tbl.push_back(mk(1, 1, 4'b0000, pk(8'h00, 8'h01, 8'h02, 8'h03), 4'b0000, 0, 10'h000, 0));
    for (int r = 0; r < FT; r++) begin
      tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h01, 8'h02, 8'h03), 4'b0010, 1, 10'h101, 8'(r)));
      tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h01, 8'h02, 8'h03), 4'b0100, 1, 10'h202, 8'(r)));
      tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h01, 8'h02, 8'h03), 4'b1000, 1, 10'h303, 8'(r + 1)));
    end
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(0, 1, 4'b1111, pk(8'h40, 8'h01, 8'h02, 8'h03), 4'b0001, 1, 10'h040, 9));
      tbl.push_back(mk(0, 1, 4'b1111, pk(8'h40, 8'h01, 8'h02, 8'h03), 4'b0010, 1, 10'h101, 9));
      tbl.push_back(mk(0, 1, 4'b1111, pk(8'h40, 8'h01, 8'h02, 8'h03), 4'b0100, 1, 10'h202, 9));
      tbl.push_back(mk(0, 1, 4'b1111, pk(8'h40, 8'h01, 8'h02, 8'h03), 4'b1000, 1, 10'h303, 9));
    end

    // No duplicates: PE1 held valid while PE2/PE3 are idle.
    tbl.push_back(mk(1, 1, 4'b0000, pk(8'h00, 8'h11, 8'h12, 8'h13), 4'b0000, 0, 10'h000, 0));
    tbl.push_back(mk(0, 1, 4'b0010, pk(8'h00, 8'h11, 8'h12, 8'h13), 4'b0010, 1, 10'h111, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 4'b0010, pk(8'h00, 8'h11, 8'h12, 8'h13), 4'b0000, 0, 10'h111, 0));
    tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h11, 8'h12, 8'h13), 4'b0100, 1, 10'h212, 0));
    tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h11, 8'h12, 8'h13), 4'b1000, 1, 10'h313, 1));
    tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h11, 8'h12, 8'h13), 4'b0010, 1, 10'h111, 1));

    // Backpressure: output held for 4 cycles after the first packet.
    tbl.push_back(mk(1, 1, 4'b0000, pk(8'h00, 8'h0A, 8'h0B, 8'h0C), 4'b0000, 0, 10'h000, 0));
    tbl.push_back(mk(0, 0, 4'b0010, pk(8'h00, 8'h0A, 8'h0B, 8'h0C), 4'b0010, 1, 10'h10A, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 4'b1110, pk(8'h00, 8'h0A, 8'h0B, 8'h0C), 4'b0000, 1, 10'h10A, 0));
    tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h0A, 8'h0B, 8'h0C), 4'b0100, 1, 10'h20B, 0));
    tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h0A, 8'h0B, 8'h0C), 4'b1000, 1, 10'h30C, 1));

    // Mid-round reset discards the partial round.
    tbl.push_back(mk(1, 1, 4'b0000, pk(8'h00, 8'h21, 8'h22, 8'h23), 4'b0000, 0, 10'h000, 0));
    tbl.push_back(mk(0, 1, 4'b0110, pk(8'h00, 8'h21, 8'h22, 8'h23), 4'b0010, 1, 10'h121, 0));
    tbl.push_back(mk(0, 1, 4'b0110, pk(8'h00, 8'h21, 8'h22, 8'h23), 4'b0100, 1, 10'h222, 0));
    tbl.push_back(mk(1, 1, 4'b1110, pk(8'h00, 8'h21, 8'h22, 8'h23), 4'b0000, 0, 10'h000, 0));
    tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h21, 8'h22, 8'h23), 4'b0010, 1, 10'h121, 0));
    tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h21, 8'h22, 8'h23), 4'b0100, 1, 10'h222, 0));
    tbl.push_back(mk(0, 1, 4'b1110, pk(8'h00, 8'h21, 8'h22, 8'h23), 4'b1000, 1, 10'h323, 1));

    for (int i = 0; i < tbl.size(); i++) apply_vec(i, tbl[i]);

    // Randomized run against the reference model.
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        rst;
      logic        ordy;
      logic [3:0]  vld;
      logic [31:0] dat;
      logic [3:0]  e_rdy;
      int          g;
      rst  = (i == 0) || ($urandom_range(0, 299) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < 4; s++) vld[s] = ($urandom_range(0, 3) != 0);
      dat  = $urandom;
      g    = model_grant(rst, ordy, vld);
      e_rdy = 4'b0000;
      if (g >= 0) e_rdy[g] = 1'b1;
      drive(rst, ordy, vld, dat);
      chk($sformatf("r%0d in_ready", i), 32'(in_ready), 32'(e_rdy));
      model_update(rst, ordy, dat, g);
      @(posedge clk);
      #1;
      chk($sformatf("r%0d out_valid", i), 32'(out_valid), 32'(m_ov));
      if (m_ov)
        chk($sformatf("r%0d out_data", i), 32'(out_data), 32'(m_od));
      chk($sformatf("r%0d round_cnt", i), 32'(round_cnt), 32'(m_cnt));
      chk($sformatf("r%0d warm", i), 32'(warm), 32'(m_cnt == FT));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
